// File: rtl/jtag_tap_ir.sv
// rtl/jtag_tap_ir.sv - JTAG TAP controller with instruction register, BYPASS/IDCODE DRs and user decode
//
// Purpose : IEEE 1149.1 16-state TAP controller running entirely in the TCK
//           domain. Holds the instruction register, the BYPASS register and
//           (optionally) the IDCODE register, decodes user instructions and
//           multiplexes TDO. External user DRs qualify the global
//           capture/shift/update strobes with SEL_USER.
// Option  : JTAG_IDCODE_EN - when defined, builds the IDCODE register and its
//           opcode decode, and Test_Logic_Reset loads IDCODE_OP into IR.
//           When undefined, IDCODE_OP decodes as BYPASS and reset loads
//           all-ones into IR.
// Ports   : TCK                 clock, all state changes on the rising edge
//           TRST_B              synchronous active-low reset
//           TMS, TDI            JTAG mode select and serial data in
//           USER_TDO[NUM_USER]  serial outputs of the external user DRs
//           TDO, TDO_EN         serial data out and its shift-state enable
//           IR[IR_WIDTH]        current (updated) instruction
//           SEL_USER[NUM_USER]  one-hot user instruction decode
//           TLRESET .. UPDT_IR  registered TAP state strobes
module jtag_tap_ir #(
    parameter int          IR_WIDTH   = 8,
    parameter int          NUM_USER   = 4,
    parameter int          USER_BASE  = 2,
    parameter int          IDCODE_OP  = 1,
    parameter logic [31:0] IDCODE_VAL = 32'h10DB0093
) (
    input  logic                TCK,
    input  logic                TRST_B,
    input  logic                TMS,
    input  logic                TDI,
    input  logic [NUM_USER-1:0] USER_TDO,
    output logic                TDO,
    output logic                TDO_EN,
    output logic [IR_WIDTH-1:0] IR,
    output logic [NUM_USER-1:0] SEL_USER,
    output logic                TLRESET,
    output logic                RTIDLE,
    output logic                CAP_DR,
    output logic                SHFT_DR,
    output logic                UPDT_DR,
    output logic                CAP_IR,
    output logic                SHFT_IR,
    output logic                UPDT_IR
);

    typedef enum logic [3:0] {
        S_TLR,
        S_RTI,
        S_SEL_DR,
        S_CAP_DR,
        S_SHIFT_DR,
        S_EXIT1_DR,
        S_PAUSE_DR,
        S_EXIT2_DR,
        S_UPDT_DR,
        S_SEL_IR,
        S_CAP_IR,
        S_SHIFT_IR,
        S_EXIT1_IR,
        S_PAUSE_IR,
        S_EXIT2_IR,
        S_UPDT_IR
    } tap_state_t;

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(IDCODE_OP);
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IR_RESET   = IR_IDCODE;
`else
    localparam logic [IR_WIDTH-1:0] IR_RESET   = '1;
`endif

    tap_state_t          state;
    tap_state_t          next_state;
    logic [IR_WIDTH-1:0] ir_sr;
    logic                bypass_sr;
    logic                op_is_idcode;
    logic                sel_idcode;
    logic                dr_tdo;

    always_comb begin
        next_state = state;
        case (state)
            S_TLR:      next_state = TMS ? S_TLR      : S_RTI;
            S_RTI:      next_state = TMS ? S_SEL_DR   : S_RTI;
            S_SEL_DR:   next_state = TMS ? S_SEL_IR   : S_CAP_DR;
            S_CAP_DR:   next_state = TMS ? S_EXIT1_DR : S_SHIFT_DR;
            S_SHIFT_DR: next_state = TMS ? S_EXIT1_DR : S_SHIFT_DR;
            S_EXIT1_DR: next_state = TMS ? S_UPDT_DR  : S_PAUSE_DR;
            S_PAUSE_DR: next_state = TMS ? S_EXIT2_DR : S_PAUSE_DR;
            S_EXIT2_DR: next_state = TMS ? S_UPDT_DR  : S_SHIFT_DR;
            S_UPDT_DR:  next_state = TMS ? S_SEL_DR   : S_RTI;
            S_SEL_IR:   next_state = TMS ? S_TLR      : S_CAP_IR;
            S_CAP_IR:   next_state = TMS ? S_EXIT1_IR : S_SHIFT_IR;
            S_SHIFT_IR: next_state = TMS ? S_EXIT1_IR : S_SHIFT_IR;
            S_EXIT1_IR: next_state = TMS ? S_UPDT_IR  : S_PAUSE_IR;
            S_PAUSE_IR: next_state = TMS ? S_EXIT2_IR : S_PAUSE_IR;
            S_EXIT2_IR: next_state = TMS ? S_UPDT_IR  : S_SHIFT_IR;
            S_UPDT_IR:  next_state = TMS ? S_SEL_DR   : S_RTI;
            default:    next_state = S_TLR;
        endcase
    end

    // Strobes are registered from next_state so each one is high exactly
    // while the state register holds its named state. Shift/capture/update
    // actions key off the current state, i.e. they happen on the edge that
    // leaves the state.
    always_ff @(posedge TCK) begin
        if (!TRST_B) begin
            state     <= S_TLR;
            TLRESET   <= 1'b1;
            RTIDLE    <= 1'b0;
            CAP_DR    <= 1'b0;
            SHFT_DR   <= 1'b0;
            UPDT_DR   <= 1'b0;
            CAP_IR    <= 1'b0;
            SHFT_IR   <= 1'b0;
            UPDT_IR   <= 1'b0;
            IR        <= IR_RESET;
            ir_sr     <= '0;
            bypass_sr <= 1'b0;
        end else begin
            state     <= next_state;
            TLRESET   <= (next_state == S_TLR);
            RTIDLE    <= (next_state == S_RTI);
            CAP_DR    <= (next_state == S_CAP_DR);
            SHFT_DR   <= (next_state == S_SHIFT_DR);
            UPDT_DR   <= (next_state == S_UPDT_DR);
            CAP_IR    <= (next_state == S_CAP_IR);
            SHFT_IR   <= (next_state == S_SHIFT_IR);
            UPDT_IR   <= (next_state == S_UPDT_IR);

            case (state)
                S_CAP_IR:   ir_sr <= IR_CAPTURE;
                S_SHIFT_IR: ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};
                default:    ir_sr <= ir_sr;
            endcase

            // IR is reloaded on the edge entering Test_Logic_Reset so the
            // default instruction is visible as soon as TLRESET rises.
            if (state == S_UPDT_IR) begin
                IR <= ir_sr;
            end else if (next_state == S_TLR) begin
                IR <= IR_RESET;
            end

            if (state == S_CAP_DR) begin
                bypass_sr <= 1'b0;
            end else if (state == S_SHIFT_DR) begin
                bypass_sr <= TDI;
            end
        end
    end

    assign op_is_idcode = (IR == IR_IDCODE);

`ifdef JTAG_IDCODE_EN
    logic [31:0] idcode_sr;

    always_ff @(posedge TCK) begin
        if (!TRST_B) begin
            idcode_sr <= '0;
        end else if (state == S_CAP_DR) begin
            idcode_sr <= IDCODE_VAL;
        end else if (state == S_SHIFT_DR) begin
            idcode_sr <= {TDI, idcode_sr[31:1]};
        end
    end

    assign sel_idcode = op_is_idcode;
`else
    logic unused_idcode;

    assign unused_idcode = ^IDCODE_VAL;
    assign sel_idcode    = 1'b0;
`endif

    // IDCODE_OP never selects a user DR, even when user opcodes overlap it.
    for (genvar i = 0; i < NUM_USER; i++) begin : g_user_dec
        assign SEL_USER[i] = (IR == IR_WIDTH'(USER_BASE + i)) && !op_is_idcode;
    end

    always_comb begin
        dr_tdo = bypass_sr;
        if (|SEL_USER) begin
            dr_tdo = |(USER_TDO & SEL_USER);
        end
`ifdef JTAG_IDCODE_EN
        if (sel_idcode) begin
            dr_tdo = idcode_sr[0];
        end
`endif
    end

    always_comb begin
        TDO = 1'b0;
        if (SHFT_IR) begin
            TDO = ir_sr[0];
        end else if (SHFT_DR) begin
            TDO = dr_tdo;
        end
    end

    assign TDO_EN = SHFT_IR | SHFT_DR;

endmodule
